// File: rtl/systema_pio_pkg.sv
// ----------------------------------------------------------------------------
// systema_pio_pkg
//   Shared definitions for the systema PIO input block:
//     - reg_addr_e : Avalon word offsets of the four slave registers
//     - EDGE_*     : edge-capture mode selectors for the EDGE_MODE parameter
//     - edge_match : per-bit edge qualifier for a given mode
// ----------------------------------------------------------------------------
package systema_pio_pkg;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,   // debounced input value
        REG_MASK = 2'd1,   // interrupt mask
        REG_CAPT = 2'd2,   // sticky edge capture, write-1-to-clear
        REG_RAW  = 2'd3    // synchronised, unfiltered input
    } reg_addr_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // True when the transition prev -> cur is one the given mode captures.
    function automatic logic edge_match(input int unsigned mode,
                                        input logic        prev,
                                        input logic        cur);
        logic hit;
        case (mode)
            EDGE_RISE: hit = ~prev &  cur;
            EDGE_FALL: hit =  prev & ~cur;
            default:   hit =  prev ^  cur;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/systema_pio_bit_filter.sv
// ----------------------------------------------------------------------------
// systema_pio_bit_filter
//   One input bit: SYNC_STAGES-deep synchroniser followed by a debounce
//   counter. A change at the synchroniser output is accepted into 'filtered'
//   only after it has been stable for DEBOUNCE_CYCLES consecutive clocks.
//   Before the block is armed, 'filtered' follows 'sync' directly so that the
//   post-reset input level is adopted without looking like a transition.
//
// Ports
//   clk       in  1  system clock
//   reset     in  1  synchronous, active-high reset
//   armed     in  1  debounce enabled (low: filtered tracks sync)
//   din       in  1  asynchronous external input
//   sync      out 1  synchronised input (last synchroniser stage)
//   filtered  out 1  debounced input
// ----------------------------------------------------------------------------
module systema_pio_bit_filter #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic armed,
    input  logic din,
    output logic sync,
    output logic filtered
);

    // One spare bit above clog2 keeps DEBOUNCE_CYCLES-1 representable for
    // every legal DEBOUNCE_CYCLES, including 1.
    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            filtered <= 1'b0;
            cnt      <= '0;
        end else if (!armed) begin
            filtered <= sync;
            cnt      <= '0;
        end else if (sync != filtered) begin
            if (cnt == CNT_LAST) begin
                filtered <= sync;
                cnt      <= '0;
            end else begin
                cnt      <= cnt + CW'(1);
            end
        end else begin
            // Any return to the accepted level restarts the stability window.
            cnt <= '0;
        end
    end

endmodule

// File: rtl/systema_pio_in_irq.sv
// ----------------------------------------------------------------------------
// systema_pio_in_irq
//   Avalon-MM slave input port with per-bit synchronise + debounce, sticky
//   edge capture and a maskable level interrupt.
//
//   Register map (word offsets, all reads zero-extended to 32 bits):
//     0  filtered data           read only
//     1  irq mask                read/write
//     2  edge capture            read, write-1-to-clear
//     3  raw synchronised input  read only
//   readdata is registered from 'address' every clock (one cycle latency).
//
// Ports
//   clk         in   1      system clock
//   reset       in   1      synchronous, active-high reset
//   address     in   2      register select
//   chipselect  in   1      slave select, qualifies writes
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data, bits above WIDTH ignored
//   in_port     in   WIDTH  asynchronous external inputs
//   readdata    out  32     registered read data
//   irq         out  1      level interrupt, |(capture & mask)
// ----------------------------------------------------------------------------
module systema_pio_in_irq
    import systema_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_MODE       = EDGE_RISE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int unsigned   ARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int unsigned   AW         = $clog2(ARM_CYCLES) + 1;
    localparam logic [AW-1:0] ARM_LAST   = AW'(ARM_CYCLES - 1);

    logic [AW-1:0]    arm_cnt;
    logic             armed;
    logic             armed_q;

    logic [WIDTH-1:0] sync_vec;
    logic [WIDTH-1:0] filt_vec;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] capture;

    logic             wr_en;
    reg_addr_e        sel;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] capture_next;
    logic [31:0]      rd_next;

    // Upper writedata bits are don't-care when WIDTH < 32.
    logic             unused_wdata;
    assign unused_wdata = ^(writedata >> WIDTH);

    // ------------------------------------------------------------------
    // Arming: wait until the synchronisers and debounce windows have seen
    // a full pass of post-reset input before edges may be captured.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed;
            if (!armed) begin
                if (arm_cnt == ARM_LAST) begin
                    armed <= 1'b1;
                end else begin
                    arm_cnt <= arm_cnt + AW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-bit synchroniser and debounce
    // ------------------------------------------------------------------
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        systema_pio_bit_filter #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filter (
            .clk      (clk),
            .reset    (reset),
            .armed    (armed),
            .din      (in_port[g]),
            .sync     (sync_vec[g]),
            .filtered (filt_vec[g])
        );
    end

    // ------------------------------------------------------------------
    // Next-state for mask, capture and read mux
    // ------------------------------------------------------------------
    always_comb begin
        wr_en = chipselect & ~write_n;
        sel   = reg_addr_e'(address);
        wdata = writedata[WIDTH-1:0];

        // Edges are qualified with armed delayed by one clock: the last
        // unarmed update of filtered lands on the same edge that sets armed,
        // and its filt_q difference is still visible on the following cycle.
        edge_set = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            edge_set[i] = armed_q & edge_match(EDGE_MODE, filt_q[i], filt_vec[i]);
        end

        mask_next = mask;
        if (wr_en && sel == REG_MASK) begin
            mask_next = wdata;
        end

        // Clear first, then set, so a new edge beats a same-cycle W1C.
        capture_next = capture;
        if (wr_en && sel == REG_CAPT) begin
            capture_next = capture & ~wdata;
        end
        capture_next = capture_next | edge_set;

        rd_next = '0;
        unique case (sel)
            REG_DATA: rd_next = 32'(filt_vec);
            REG_MASK: rd_next = 32'(mask);
            REG_CAPT: rd_next = 32'(capture);
            REG_RAW:  rd_next = 32'(sync_vec);
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= '0;
            capture  <= '0;
            filt_q   <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            mask     <= mask_next;
            capture  <= capture_next;
            filt_q   <= filt_vec;
            readdata <= rd_next;
            irq      <= |(capture_next & mask_next);
        end
    end

endmodule

// File: tb/tb_systema_pio_in_irq.sv
module tb_systema_pio_in_irq;
    import systema_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Rising-edge instance
    systema_pio_in_irq #(
        .WIDTH           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .EDGE_MODE       (EDGE_RISE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_a),
        .readdata   (rd_a),
        .irq        (irq_a)
    );

    // Any-edge instance, shares the bus
    systema_pio_in_irq #(
        .WIDTH           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .EDGE_MODE       (EDGE_ANY)
    ) dut_any (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_b),
        .readdata   (rd_b),
        .irq        (irq_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_a       = 8'hFF;
        in_b       = 8'h00;
        tick(2);
        check("rst_rdata", rd_a, 32'h0);
        check("rst_irq", {31'b0, irq_a}, 32'h0);

        // High input at reset: adopted as data, no edge captured
        reset = 1'b0;
        tick(7);
        check("arm_data_ff", rd_a, 32'h0000_00FF);
        address = 2'd2;
        tick(1);
        check("arm_capt", rd_a, 32'h0);
        check("arm_irq", {31'b0, irq_a}, 32'h0);

        // Falling edge ignored in rising mode
        in_a = 8'h00;
        tick(12);
        check("fall_no_capt", rd_a, 32'h0);
        address = 2'd0;
        tick(1);
        check("fall_data", rd_a, 32'h0);

        // Rising bit 0: data visible after 2+4+1 clocks, not before
        in_a = 8'h01;
        tick(6);
        check("db_not_yet", rd_a, 32'h0);
        tick(1);
        check("db_done", rd_a, 32'h1);
        address = 2'd2;
        tick(1);
        check("rise_capt", rd_a, 32'h1);
        check("rise_irq_masked", {31'b0, irq_a}, 32'h0);
        address = 2'd3;
        tick(1);
        check("raw_01", rd_a, 32'h1);

        // Unmask -> irq next clk; W1C -> irq drops next clk
        bus_write(2'd1, 32'h1);
        check("mask_irq_on", {31'b0, irq_a}, 32'h1);
        tick(1);
        check("mask_read", rd_a, 32'h1);
        bus_write(2'd2, 32'h1);
        check("w1c_irq_off", {31'b0, irq_a}, 32'h0);
        tick(1);
        check("w1c_capt", rd_a, 32'h0);

        // 3-clock pulse on bit 3: visible raw, rejected by debounce
        bus_write(2'd1, 32'h8);
        address = 2'd3;
        in_a    = 8'h09;
        tick(3);
        check("glitch_raw", rd_a, 32'h9);
        in_a = 8'h01;
        tick(10);
        check("glitch_raw_end", rd_a, 32'h1);
        address = 2'd0;
        tick(1);
        check("glitch_data", rd_a, 32'h1);
        address = 2'd2;
        tick(1);
        check("glitch_capt", rd_a, 32'h0);
        check("glitch_irq", {31'b0, irq_a}, 32'h0);

        // Edge and W1C on the same clock: set wins
        in_a = 8'h00;
        tick(10);
        in_a = 8'h01;
        tick(10);
        check("pre_w1c_capt", rd_a, 32'h1);
        in_a = 8'h00;
        tick(10);
        in_a = 8'h01;
        tick(6);
        bus_write(2'd2, 32'h1);
        tick(1);
        check("set_wins", rd_a, 32'h1);
        bus_write(2'd2, 32'h1);
        tick(1);
        check("w1c_after", rd_a, 32'h0);

        // Any-edge instance: bit 7 rise then fall, irq each time
        bus_write(2'd1, 32'h80);
        in_b = 8'h80;
        tick(6);
        check("any_rise_early", {31'b0, irq_b}, 32'h0);
        tick(1);
        check("any_rise_irq", {31'b0, irq_b}, 32'h1);
        check("rise_mode_quiet", {31'b0, irq_a}, 32'h0);
        address = 2'd2;
        tick(1);
        check("any_rise_capt", rd_b, 32'h80);
        bus_write(2'd2, 32'h80);
        check("any_w1c_irq", {31'b0, irq_b}, 32'h0);
        tick(1);
        check("any_w1c_capt", rd_b, 32'h0);
        in_b = 8'h00;
        tick(7);
        check("any_fall_irq", {31'b0, irq_b}, 32'h1);
        tick(1);
        check("any_fall_capt", rd_b, 32'h80);
        bus_write(2'd2, 32'h80);
        check("any_w1c2_irq", {31'b0, irq_b}, 32'h0);

        // Reset with a pending capture and a debounce in flight
        in_b = 8'h80;
        tick(7);
        check("pend_irq", {31'b0, irq_b}, 32'h1);
        in_a = 8'h00;
        tick(3);
        reset = 1'b1;
        tick(1);
        check("midrst_rd_b", rd_b, 32'h0);
        check("midrst_irq_b", {31'b0, irq_b}, 32'h0);
        check("midrst_rd_a", rd_a, 32'h0);
        reset   = 1'b0;
        address = 2'd2;
        tick(9);
        check("postrst_capt_b", rd_b, 32'h0);
        check("postrst_irq_b", {31'b0, irq_b}, 32'h0);
        address = 2'd1;
        tick(1);
        check("postrst_mask", rd_b, 32'h0);
        address = 2'd0;
        tick(1);
        check("postrst_data_a", rd_a, 32'h0);
        check("postrst_data_b", rd_b, 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
